// File: rtl/cruise_pkg.sv
// Shared definitions for the cruise speed controller: state encoding,
// default speed limits and the settle counter width.
package cruise_pkg;

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_ACCEL = 2'd2;
  localparam logic [1:0] ST_DECEL = 2'd3;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_MIN_SPEED = 40;
  localparam int DEF_MAX_SPEED = 200;
  localparam int DEF_SETTLE    = 4;

  // Settle counter width; SETTLE must stay within 1..15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/cruise_speed_controller_settle_filter.sv
// Debounces comparator results: asserts go_up / go_down combinationally in
// the cycle where the SETTLE-th consecutive identical L / G sample arrives.
module settle_filter
  import cruise_pkg::*;
#(
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic clk,
  input  logic reset,
  input  logic g,
  input  logic l,
  input  logic valid,
  input  logic clear,
  output logic go_up,
  output logic go_down
);

  localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);

  logic [CNT_W-1:0] count_q, count_d, run_d, count_inc;
  logic             dir_q, dir_d;

  // Next run length: a directional sample extends or restarts the run,
  // Eq or an invalid pattern breaks it; clear overrides the stored value only.
  always_comb begin
    count_inc = (count_q == '1) ? count_q : count_q + CNT_W'(1);
    run_d     = '0;
    dir_d     = dir_q;
    if (valid && (g || l)) begin
      dir_d = l;
      if ((count_q != '0) && (dir_q == l)) begin
        run_d = count_inc;
      end else begin
        run_d = CNT_W'(1);
      end
    end
    go_up   = valid && l && (run_d == SETTLE_C);
    go_down = valid && g && (run_d == SETTLE_C);
    count_d = clear ? '0 : run_d;
  end

  // Count and direction registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      dir_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      dir_q   <= dir_d;
    end
  end

endmodule

// File: rtl/cruise_speed_controller.sv
// Cruise speed controller: owns the set-speed register and runs a Moore FSM
// that turns filtered comparator results into throttle up/down commands.
module cruise_speed_controller
  import cruise_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MIN_SPEED = DEF_MIN_SPEED,
  parameter int MAX_SPEED = DEF_MAX_SPEED,
  parameter int SETTLE    = DEF_SETTLE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] speed,
  input  logic             cruise_on,
  input  logic             cruise_off,
  input  logic             brake,
  input  logic             inc,
  input  logic             dec,
  input  logic             cmp_g,
  input  logic             cmp_eq,
  input  logic             cmp_l,
  output logic [WIDTH-1:0] set_speed,
  output logic             active,
  output logic             throttle_up,
  output logic             throttle_down
);

  localparam logic [WIDTH-1:0] MIN_C = WIDTH'(MIN_SPEED);
  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_SPEED);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] set_q, set_d;
  logic             active_q, up_q, down_q;
  logic             valid, go_up, go_down, restart, flt_clear;

  // Settling comparator outputs may show zero or several bits; only one-hot counts.
  assign valid = $onehot({cmp_g, cmp_eq, cmp_l});

  // Filter history only lives while HOLD persists across the edge.
  assign flt_clear = restart || (state_q != ST_HOLD) || (state_d != ST_HOLD);

  settle_filter #(
    .SETTLE(SETTLE)
  ) u_filter (
    .clk    (clk),
    .reset  (reset),
    .g      (cmp_g),
    .l      (cmp_l),
    .valid  (valid),
    .clear  (flt_clear),
    .go_up  (go_up),
    .go_down(go_down)
  );

  // Next state and set speed in priority order: brake/off, capture, buttons, comparator.
  always_comb begin
    state_d = state_q;
    set_d   = set_q;
    restart = 1'b0;
    if (brake || cruise_off) begin
      state_d = ST_OFF;
    end else if (cruise_on && (speed >= MIN_C)) begin
      state_d = ST_HOLD;
      set_d   = speed;
      restart = 1'b1;
    end else if ((state_q != ST_OFF) && (inc != dec) &&
                 (inc ? (set_q < MAX_C) : (set_q > MIN_C))) begin
      set_d   = inc ? set_q + WIDTH'(1) : set_q - WIDTH'(1);
      state_d = ST_HOLD;
      restart = 1'b1;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (go_up)        state_d = ST_ACCEL;
          else if (go_down) state_d = ST_DECEL;
        end
        ST_ACCEL: if (valid && (cmp_eq || cmp_g)) state_d = ST_HOLD;
        ST_DECEL: if (valid && (cmp_eq || cmp_l)) state_d = ST_HOLD;
        default: ;
      endcase
    end
  end

  // State, set speed and state-decoded output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_OFF;
      set_q    <= '0;
      active_q <= 1'b0;
      up_q     <= 1'b0;
      down_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      set_q    <= set_d;
      active_q <= (state_d != ST_OFF);
      up_q     <= (state_d == ST_ACCEL);
      down_q   <= (state_d == ST_DECEL);
    end
  end

  assign set_speed     = set_q;
  assign active        = active_q;
  assign throttle_up   = up_q;
  assign throttle_down = down_q;

endmodule
